// File: rtl/binary_splitter_if.sv
// -----------------------------------------------------------------------------
// binary_splitter_if
//   Flit bus for the 1-to-2 packet splitter.
//   Ports (signals):
//     in / in_valid / in_avail           : input flit stream
//     out0 / out0_valid / out0_avail     : output port 0 stream
//     out1 / out1_valid / out1_avail     : output port 1 stream
//     err                                : sticky protocol-error flag
//   Modports:
//     master : traffic source and sink side (drives in, in_valid, outX_avail)
//     slave  : the splitter itself
// -----------------------------------------------------------------------------
interface binary_splitter_if #(
    parameter int FLIT_SIZE = 64
);
    logic [FLIT_SIZE-1:0] in;
    logic                 in_valid;
    logic                 in_avail;
    logic [FLIT_SIZE-1:0] out0;
    logic                 out0_valid;
    logic                 out0_avail;
    logic [FLIT_SIZE-1:0] out1;
    logic                 out1_valid;
    logic                 out1_avail;
    logic                 err;

    modport master (
        output in, in_valid, out0_avail, out1_avail,
        input  in_avail, out0, out0_valid, out1, out1_valid, err
    );

    modport slave (
        input  in, in_valid, out0_avail, out1_avail,
        output in_avail, out0, out0_valid, out1, out1_valid, err
    );
endinterface

// File: rtl/binary_splitter.sv
// -----------------------------------------------------------------------------
// binary_splitter
//   Packet-aware 1-to-2 flit distributor. The route bit of each head or single
//   flit selects out0 or out1; body and tail flits follow their head. Each
//   output owns a 2-entry FIFO so a stalled port never blocks the other.
//
//   Ports:
//     clk  : clock, rising edge
//     rst  : synchronous reset, active-low
//     bus  : binary_splitter_if.slave (in/in_valid/in_avail, out0/out0_valid/
//            out0_avail, out1/out1_valid/out1_avail, err)
//
//   Build option:
//     SPLIT_ORPHAN_DROP_EN : when defined, a body/tail flit arriving in IDLE is
//                            accepted and discarded; otherwise it is forwarded
//                            to out0. Either way err is raised.
// -----------------------------------------------------------------------------
module binary_splitter #(
    parameter int FLIT_SIZE  = 64,
    parameter int HEADER_LEN = 2,
    parameter int ROUTE_POS  = 40
) (
    input logic               clk,
    input logic               rst,
    binary_splitter_if.slave  bus
);
    localparam logic [HEADER_LEN-1:0] HEAD_FLIT   = HEADER_LEN'(2'b10);
    localparam logic [HEADER_LEN-1:0] BODY_FLIT   = HEADER_LEN'(2'b00);
    localparam logic [HEADER_LEN-1:0] TAIL_FLIT   = HEADER_LEN'(2'b01);
    localparam logic [HEADER_LEN-1:0] SINGLE_FLIT = HEADER_LEN'(2'b11);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PKT0 = 2'd1,
        PKT1 = 2'd2
    } state_t;

    state_t                state, state_nxt;

    logic [HEADER_LEN-1:0] flit_type;
    logic                  route;
    logic                  is_head, is_single, is_tail, is_start;
    logic                  orphan, drop, tgt;
    logic                  accept, err_set, err_q, in_avail_c;

    logic [1:0]            avail, pop, push, space;
    logic [1:0]            cnt [2];
    logic                  wp  [2];
    logic                  rp  [2];
    logic [FLIT_SIZE-1:0]  mem [2][2];

    // Decode, steering and flow control
    always_comb begin
        flit_type = bus.in[FLIT_SIZE-1 -: HEADER_LEN];
        route     = bus.in[ROUTE_POS];
        is_head   = (flit_type == HEAD_FLIT);
        is_single = (flit_type == SINGLE_FLIT);
        is_tail   = (flit_type == TAIL_FLIT);
        is_start  = is_head || is_single;

        // Body/tail with no open packet. BODY_FLIT is implied by !is_start.
        orphan    = !is_start && (state == IDLE);
`ifdef SPLIT_ORPHAN_DROP_EN
        drop      = orphan;
`else
        drop      = 1'b0;
`endif

        // A head/single always routes by its own bit, even mid-packet;
        // orphans (when forwarded) go to port 0.
        if (is_start)
            tgt = route;
        else
            tgt = (state == PKT1);

        avail = {bus.out1_avail, bus.out0_avail};
        for (int p = 0; p < 2; p++) begin
            pop[p]   = (cnt[p] != 2'd0) && avail[p];
            // A full FIFO can still take a flit when it pops this cycle.
            space[p] = (cnt[p] < 2'd2) || pop[p];
        end

        if (!rst)
            in_avail_c = 1'b0;
        else if (!bus.in_valid)
            in_avail_c = space[0] || space[1];
        else if (drop)
            in_avail_c = 1'b1;
        else
            in_avail_c = tgt ? space[1] : space[0];

        accept  = bus.in_valid && in_avail_c;
        push[0] = accept && !drop && !tgt;
        push[1] = accept && !drop &&  tgt;
        err_set = accept && ((is_start && (state != IDLE)) || orphan);
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (accept) begin
            if (is_head)
                state_nxt = route ? PKT1 : PKT0;
            else if (is_single || is_tail)
                state_nxt = IDLE;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // FIFO control and sticky error
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_q <= 1'b0;
            for (int p = 0; p < 2; p++) begin
                cnt[p] <= 2'd0;
                wp[p]  <= 1'b0;
                rp[p]  <= 1'b0;
            end
        end else begin
            if (err_set)
                err_q <= 1'b1;
            for (int p = 0; p < 2; p++) begin
                if (push[p])
                    wp[p] <= ~wp[p];
                if (pop[p])
                    rp[p] <= ~rp[p];
                case ({push[p], pop[p]})
                    2'b10:   cnt[p] <= cnt[p] + 2'd1;
                    2'b01:   cnt[p] <= cnt[p] - 2'd1;
                    default: cnt[p] <= cnt[p];
                endcase
            end
        end
    end

    // FIFO storage; push is already held off during reset via in_avail.
    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (push[p])
                mem[p][wp[p]] <= bus.in;
        end
    end

    // Outputs read as zero while a FIFO is empty, which also covers reset.
    assign bus.in_avail   = in_avail_c;
    assign bus.out0_valid = (cnt[0] != 2'd0);
    assign bus.out1_valid = (cnt[1] != 2'd0);
    assign bus.out0       = (cnt[0] != 2'd0) ? mem[0][rp[0]] : '0;
    assign bus.out1       = (cnt[1] != 2'd0) ? mem[1][rp[1]] : '0;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_binary_splitter.sv
// -----------------------------------------------------------------------------
// tb_binary_splitter
//   Drives the splitter with directed packet sequences followed by random
//   traffic and compares every cycle against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_binary_splitter;
    logic clk = 1'b0;
    logic rst;

    binary_splitter_if #(.FLIT_SIZE(64)) bus ();

    binary_splitter #(
        .FLIT_SIZE (64),
        .HEADER_LEN(2),
        .ROUTE_POS (40)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: one queue per output, the open packet's port (-1 = none)
    logic [63:0] q0 [$];
    logic [63:0] q1 [$];
    int          cur_port = -1;
    bit          err_m    = 1'b0;
    bit          chk_en   = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic [1:0] t, input logic r);
        logic [63:0] f;
        f = {$urandom, $urandom};
        f[63:62] = t;
        f[40]    = r;
        return f;
    endfunction

    task automatic cycle(input logic r, input logic v, input logic [63:0] f,
                         input logic a0, input logic a1);
        logic [1:0] typ;
        bit start, drop, ok0, ok1, exp_av, acc;
        int tgt;
        @(negedge clk);
        rst             = r;
        bus.in_valid    = v;
        bus.in          = f;
        bus.out0_avail  = a0;
        bus.out1_avail  = a1;
        #1;
        typ   = f[63:62];
        start = (typ == 2'b10) || (typ == 2'b11);
        drop  = 1'b0;
        if (start)
            tgt = int'(f[40]);
        else if (cur_port >= 0)
            tgt = cur_port;
        else begin
            tgt = 0;
`ifdef SPLIT_ORPHAN_DROP_EN
            drop = 1'b1;
`endif
        end
        ok0 = (q0.size() < 2) || a0;
        ok1 = (q1.size() < 2) || a1;
        if (!r)          exp_av = 1'b0;
        else if (!v)     exp_av = ok0 || ok1;
        else if (drop)   exp_av = 1'b1;
        else             exp_av = (tgt == 1) ? ok1 : ok0;
        check("in_avail", 64'(bus.in_avail), 64'(exp_av));
        if (chk_en) begin
            check("out0_valid", 64'(bus.out0_valid), 64'(q0.size() != 0));
            check("out1_valid", 64'(bus.out1_valid), 64'(q1.size() != 0));
            check("out0", bus.out0, (q0.size() != 0) ? q0[0] : 64'd0);
            check("out1", bus.out1, (q1.size() != 0) ? q1[0] : 64'd0);
            check("err", 64'(bus.err), 64'(err_m));
        end
        acc = v && exp_av;
        @(posedge clk);
        chk_en = 1'b1;
        if (!r) begin
            q0.delete();
            q1.delete();
            cur_port = -1;
            err_m    = 1'b0;
        end else begin
            if (q0.size() != 0 && a0) void'(q0.pop_front());
            if (q1.size() != 0 && a1) void'(q1.pop_front());
            if (acc) begin
                if (!drop) begin
                    if (tgt == 1) q1.push_back(f);
                    else          q0.push_back(f);
                end
                if (start) begin
                    if (cur_port >= 0) err_m = 1'b1;
                    cur_port = (typ == 2'b10) ? int'(f[40]) : -1;
                end else begin
                    if (cur_port < 0) err_m = 1'b1;
                    if (typ == 2'b01) cur_port = -1;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 64'd0, 1'b1, 1'b1);
    endtask

    initial begin
        logic [63:0] s2;
        rst            = 1'b0;
        bus.in         = '0;
        bus.in_valid   = 1'b0;
        bus.out0_avail = 1'b0;
        bus.out1_avail = 1'b0;

        // Reset held for three cycles
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 64'd0, 1'b1, 1'b1);
        #1;
        check("rst_out0_valid", 64'(bus.out0_valid), 64'd0);
        check("rst_out1_valid", 64'(bus.out1_valid), 64'd0);
        check("rst_err",        64'(bus.err),        64'd0);
        check("rst_in_avail",   64'(bus.in_avail),   64'd0);
        idle(1);

        // Four-flit packet routed to out1
        cycle(1'b1, 1'b1, mk(2'b10, 1'b1), 1'b1, 1'b1);
        cycle(1'b1, 1'b1, mk(2'b00, 1'b0), 1'b1, 1'b1);
        cycle(1'b1, 1'b1, mk(2'b00, 1'b1), 1'b1, 1'b1);
        cycle(1'b1, 1'b1, mk(2'b01, 1'b0), 1'b1, 1'b1);
        idle(2);
        #1;
        check("pkt_err", 64'(bus.err), 64'd0);

        // Backpressure on out0: third single waits for the pop
        cycle(1'b1, 1'b1, mk(2'b11, 1'b0), 1'b0, 1'b1);
        cycle(1'b1, 1'b1, mk(2'b11, 1'b0), 1'b0, 1'b1);
        s2 = mk(2'b11, 1'b0);
        cycle(1'b1, 1'b1, s2, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, s2, 1'b1, 1'b1);
        idle(3);

        // Port independence: out1 full and stalled, out0 still flows
        cycle(1'b1, 1'b1, mk(2'b11, 1'b1), 1'b1, 1'b0);
        cycle(1'b1, 1'b1, mk(2'b11, 1'b1), 1'b1, 1'b0);
        cycle(1'b1, 1'b1, mk(2'b11, 1'b0), 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 64'd0, 1'b1, 1'b0);
        idle(3);

        // Head arriving mid-packet
        cycle(1'b1, 1'b1, mk(2'b10, 1'b0), 1'b1, 1'b1);
        cycle(1'b1, 1'b1, mk(2'b00, 1'b1), 1'b1, 1'b1);
        cycle(1'b1, 1'b1, mk(2'b10, 1'b1), 1'b1, 1'b1);
        cycle(1'b1, 1'b1, mk(2'b01, 1'b0), 1'b1, 1'b1);
        idle(2);
        #1;
        check("midhead_err", 64'(bus.err), 64'd1);

        // Orphan body in IDLE after a fresh reset
        cycle(1'b0, 1'b0, 64'd0, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 64'h0000_0000_0000_00A5, 1'b1, 1'b1);
        idle(2);
        #1;
        check("orphan_err", 64'(bus.err), 64'd1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 149) != 0),
                  ($urandom_range(0, 3) != 0),
                  mk(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1))),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 3) != 0));
        end
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
